clk_div_prog: RTL and testbench

Runtime-programmable clock divider with programmable high time. It generalises the fixed divide-by-2 generator to an N-bit divisor with duty control, enable gating and a boundary-synchronised configuration handshake. It sits in the clocking utilities layer and feeds slow strobes and derived clocks, such as LED scan and UART baud, from `clkin`. It also emits a one-cycle `tick` per output period for logic that must stay on the `clkin` domain.

---
 rtl/clk_div_pkg.sv | 36 +++
 rtl/clk_div_cfg.sv | 52 +++++
 rtl/clk_div_prog.sv | 87 ++++++++
 tb/tb_clk_div_prog.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, state encoding and configuration clamp for the clock utilities.
package clk_div_pkg;

  localparam int          DEFAULT_DIV_C  = 2;
  localparam int          DEFAULT_HIGH_C = 1;
  localparam logic [31:0] MIN_DIV        = 32'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
    logic        err;
  } clamp_t;

  // Works at 32 bits so every block can share it regardless of its counter width.
  function automatic clamp_t clamp_cfg(input logic [31:0] div, input logic [31:0] high);
    clamp_t r;
    r.err  = 1'b0;
    r.div  = div;
    r.high = high;
    if (div < MIN_DIV) begin
      r.div = MIN_DIV;
      r.err = 1'b1;
    end
    if (high >= r.div) begin
      r.high = r.div - 32'd1;
      r.err  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Configuration slot for clk_div_prog: clamps offered settings, holds them pending
// and raises the apply strobe at a safe point of the output waveform.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             run,
  input  logic             wrap,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             apply,
  output logic [CNT_W-1:0] div_pend,
  output logic [CNT_W-1:0] high_pend
);

  logic   pend;
  logic   hs;
  clamp_t cl;
  logic   unused_cl;

  assign cl        = clamp_cfg(32'(cfg_div), 32'(cfg_high));
  assign unused_cl = ^{cl.div, cl.high};
  assign hs        = cfg_valid & ~pend;
  assign cfg_ready = ~pend;
  // A handshake cannot coincide with apply: one needs pend low, the other pend high.
  assign apply     = pend & (~run | wrap);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      pend      <= 1'b0;
      cfg_err   <= 1'b0;
      div_pend  <= '0;
      high_pend <= '0;
    end else begin
      cfg_err <= hs & cl.err;
      if (hs) begin
        pend      <= 1'b1;
        div_pend  <= cl.div[CNT_W-1:0];
        high_pend <= cl.high[CNT_W-1:0];
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with duty control, enable gating and a
// period-boundary configuration handshake; also emits a tick per output period.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | en=0: counter parked at 0, outputs low, pending cfg applied
//   ST_RUN  | en=1: counter runs 0..div_act-1, pending cfg applied at wrap
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_C,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_C
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick
);

  state_t           st;
  logic [CNT_W-1:0] c, c_nxt;
  logic [CNT_W-1:0] div_act, high_act;
  logic [CNT_W-1:0] div_pend, high_pend;
  logic             clk_nxt, tick_nxt;
  logic             wrap, apply;

  // The mode follows en directly so a falling en parks the counter on the very next edge.
  assign st   = en ? ST_RUN : ST_IDLE;
  assign wrap = (c == div_act - CNT_W'(1));

  always_comb begin
    c_nxt    = '0;
    clk_nxt  = 1'b0;
    tick_nxt = 1'b0;
    case (st)
      ST_RUN: begin
        c_nxt    = wrap ? '0 : c + CNT_W'(1);
        clk_nxt  = (c >= div_act - high_act);
        tick_nxt = wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      c        <= '0;
      clkout   <= 1'b0;
      tick     <= 1'b0;
      div_act  <= CNT_W'(DEFAULT_DIV);
      high_act <= CNT_W'(DEFAULT_HIGH);
    end else begin
      c      <= c_nxt;
      clkout <= clk_nxt;
      tick   <= tick_nxt;
      if (apply) begin
        div_act  <= div_pend;
        high_act <= high_pend;
      end
    end
  end

  clk_div_cfg #(
    .CNT_W(CNT_W)
  ) u_cfg (
    .clkin    (clkin),
    .rstn     (rstn),
    .run      (st == ST_RUN),
    .wrap     (wrap),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .apply    (apply),
    .div_pend (div_pend),
    .high_pend(high_pend)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a cycle model queues expected outputs each
// rising edge; the falling-edge monitor pops and compares them.
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clkin = 1'b0;
  logic         rstn = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_ready, cfg_err, clkout, tick;

  clk_div_prog #(
    .CNT_W       (W),
    .DEFAULT_DIV (2),
    .DEFAULT_HIGH(1)
  ) dut (
    .clkin    (clkin),
    .rstn     (rstn),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clkout   (clkout),
    .tick     (tick)
  );

  always #5 clkin = ~clkin;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit ck;
    bit tk;
    bit rdy;
    bit err;
  } exp_t;
  exp_t q[$];

  // reference model state
  int m_div = 2, m_high = 1, m_c = 0, m_pdiv = 0, m_phigh = 0;
  bit m_pend = 0, m_ck = 0, m_tk = 0, m_err = 0;

  always @(posedge clkin or negedge rstn) begin
    bit hs, wrap, apply;
    int d, h;
    if (!rstn) begin
      m_div = 2; m_high = 1; m_c = 0; m_pend = 0;
      m_ck = 0; m_tk = 0; m_err = 0;
      q.delete();
      q.push_back('{0, 0, 1, 0});
    end else begin
      hs = cfg_valid && !m_pend;
      if (en) begin
        wrap  = (m_c == m_div - 1);
        m_ck  = (m_c >= m_div - m_high);
        m_tk  = wrap;
        apply = m_pend && wrap;
        m_c   = wrap ? 0 : m_c + 1;
      end else begin
        m_ck  = 0;
        m_tk  = 0;
        apply = m_pend;
        m_c   = 0;
      end
      m_err = 0;
      if (apply) begin
        m_div  = m_pdiv;
        m_high = m_phigh;
        m_pend = 0;
      end else if (hs) begin
        d      = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        h      = (int'(cfg_high) >= d) ? d - 1 : int'(cfg_high);
        m_err  = (d != int'(cfg_div)) || (h != int'(cfg_high));
        m_pdiv = d;
        m_phigh = h;
        m_pend = 1;
      end
      q.push_back('{m_ck, m_tk, !m_pend, m_err});
    end
  end

  always @(negedge clkin) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clkout", int'(clkout), int'(e.ck));
      chk("tick", int'(tick), int'(e.tk));
      chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
      chk("cfg_err", int'(cfg_err), int'(e.err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic send_cfg(input int d, input int h);
    cfg_div   = W'(d);
    cfg_high  = W'(h);
    cfg_valid = 1'b1;
    for (int i = 0; i < 200 && !cfg_ready; i++) @(negedge clkin);
    chk("cfg_ready_wait", int'(cfg_ready), 1);
    @(negedge clkin);
    cfg_valid = 1'b0;
  endtask

  task automatic win(input string tag, input int n, input int exp_hi, input int exp_tk);
    int hi = 0, tk = 0;
    repeat (n) begin
      @(negedge clkin);
      hi += int'(clkout);
      tk += int'(tick);
    end
    chk({tag, "_high_cycles"}, hi, exp_hi);
    chk({tag, "_ticks"}, tk, exp_tk);
  endtask

  initial begin
    int k;
    cyc(3);
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_err", int'(cfg_err), 0);
    rstn = 1'b1;
    cyc(2);
    en = 1'b1;
    cyc(4);
    win("dflt", 10, 5, 5);

    send_cfg(5, 2);
    chk("ready_low_pending", int'(cfg_ready), 0);
    cyc(12);
    win("d5h2", 20, 8, 4);

    send_cfg(4, 0);
    cyc(12);
    win("d4h0", 16, 0, 4);

    send_cfg(1, 7);
    chk("err_pulse", int'(cfg_err), 1);
    cyc(1);
    chk("err_single", int'(cfg_err), 0);
    cyc(10);
    win("clamped", 10, 5, 5);

    en = 1'b0;
    cyc(2);
    send_cfg(6, 3);
    cyc(1);
    chk("idle_apply_ready", int'(cfg_ready), 1);
    en = 1'b1;
    cyc(14);
    win("d6h3", 12, 6, 2);

    cyc(2);
    en = 1'b0;
    cyc(1);
    chk("drop_clkout", int'(clkout), 0);
    chk("drop_tick", int'(tick), 0);
    cyc(3);
    en = 1'b1;
    k = 0;
    do begin
      @(negedge clkin);
      k++;
    end while (!clkout && k < 50);
    chk("first_rise_edges", k, 4);

    cyc(3);
    send_cfg(3, 1);
    chk("pend_before_rst", int'(cfg_ready), 0);
    #2 rstn = 1'b0;
    #1;
    chk("async_clkout", int'(clkout), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_ready", int'(cfg_ready), 1);
    chk("async_err", int'(cfg_err), 0);
    cyc(2);
    rstn = 1'b1;
    cyc(4);
    win("post_rst", 10, 5, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
